// File: rtl/dm_port_scheduler.sv
// Arbitrates MEM-stage (A) and loader (B) requests onto a single word-wide data memory port.
// Load/word store done in 2 cycles, sub-word store (read-modify-write) in 3, misaligned in 1; requesters stall until Done.
module dm_port_scheduler (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        A_Req,
  input  logic        A_Write,
  input  logic [1:0]  A_Size,
  input  logic        A_Signed,
  input  logic [31:0] A_Addr,
  input  logic [31:0] A_WData,
  output logic [31:0] A_RData,
  output logic        A_Done,
  output logic        A_Err,
  output logic        A_Stall,
  input  logic        B_Req,
  input  logic        B_Write,
  input  logic [31:0] B_Addr,
  input  logic [31:0] B_WData,
  output logic [31:0] B_RData,
  output logic        B_Done,
  output logic [31:0] data_address_2DM,
  output logic [31:0] data_write_2DM,
  output logic [1:0]  data_write_size_2DM,
  output logic        MemRead_2DM,
  output logic        MemWrite_2DM,
  input  logic [31:0] data_read_fDM
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic [2:0]  starve_cnt;
  logic        own_b;
  logic        op_wr;
  logic        op_sgn;
  logic [1:0]  op_size;
  logic [1:0]  op_off;
  logic [31:0] op_wdata;

  logic        grant_any;
  logic        grant_b;
  logic        g_wr;
  logic        g_sgn;
  logic        g_mis;
  logic [1:0]  g_size;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [31:0] rdata_fmt;
  logic        unused_b_addr;

  // Size is normalised to 0=word, 1=byte, 2=half; B is always a word access.
  assign grant_any = A_Req | B_Req;
  assign grant_b   = B_Req & (~A_Req | (starve_cnt == 3'd4));
  assign g_wr      = grant_b ? B_Write : A_Write;
  assign g_sgn     = ~grant_b & A_Signed;
  assign g_size    = grant_b ? 2'd0 : ((A_Size == 2'd3) ? 2'd0 : A_Size);
  assign g_addr    = grant_b ? {B_Addr[31:2], 2'b00} : A_Addr;
  assign g_wdata   = grant_b ? B_WData : A_WData;
  assign g_mis     = ((g_size == 2'd2) & g_addr[0]) | ((g_size == 2'd0) & (g_addr[1:0] != 2'd0));
  assign unused_b_addr = ^B_Addr[1:0];

  assign A_Stall             = RESET & A_Req & ~A_Done;
  assign data_write_size_2DM = 2'd0;

  // Bit position of the lane's LSB; big-endian, so offset 0 is the top of the word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] size, input logic [1:0] off);
    lane_lsb = (size == 2'd2) ? (off[1] ? 5'd0 : 5'd16) : {2'd3 - off, 3'b000};
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] size,
                                           input logic sgn, input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> lane_lsb(size, off);
    case (size)
      2'd1:    load_fmt = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd2:    load_fmt = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_fmt = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    mask  = ((size == 2'd2) ? 32'h0000_FFFF : 32'h0000_00FF) << lane_lsb(size, off);
    merge = (w & ~mask) | ((d << lane_lsb(size, off)) & mask);
  endfunction

  assign rdata_fmt = load_fmt(data_read_fDM, op_size, op_sgn, op_off);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      own_b            <= 1'b0;
      op_wr            <= 1'b0;
      op_sgn           <= 1'b0;
      op_size          <= '0;
      op_off           <= '0;
      op_wdata         <= '0;
      A_RData          <= '0;
      A_Done           <= 1'b0;
      A_Err            <= 1'b0;
      B_RData          <= '0;
      B_Done           <= 1'b0;
      data_address_2DM <= '0;
      data_write_2DM   <= '0;
      MemRead_2DM      <= 1'b0;
      MemWrite_2DM     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            own_b    <= grant_b;
            op_wr    <= g_wr;
            op_sgn   <= g_sgn;
            op_size  <= g_size;
            op_off   <= g_addr[1:0];
            op_wdata <= g_wdata;
            if (grant_b)
              starve_cnt <= '0;
            else if (B_Req && starve_cnt != 3'd4)
              starve_cnt <= starve_cnt + 3'd1;
            if (g_mis) begin
              state  <= DONE;
              A_Done <= 1'b1;
              A_Err  <= 1'b1;
            end else if (g_wr && g_size == 2'd0) begin
              state            <= WR;
              MemWrite_2DM     <= 1'b1;
              data_write_2DM   <= g_wdata;
              data_address_2DM <= {g_addr[31:2], 2'b00};
            end else begin
              state            <= RD;
              MemRead_2DM      <= 1'b1;
              data_address_2DM <= {g_addr[31:2], 2'b00};
            end
          end
        end
        RD: begin
          MemRead_2DM <= 1'b0;
          if (op_wr) begin
            // Sub-word store: write back the fetched word with only the addressed lane replaced.
            state          <= WR;
            MemWrite_2DM   <= 1'b1;
            data_write_2DM <= merge(data_read_fDM, op_wdata, op_size, op_off);
          end else begin
            state            <= DONE;
            data_address_2DM <= '0;
            if (own_b) begin
              B_Done  <= 1'b1;
              B_RData <= rdata_fmt;
            end else begin
              A_Done  <= 1'b1;
              A_RData <= rdata_fmt;
            end
          end
        end
        WR: begin
          state            <= DONE;
          MemWrite_2DM     <= 1'b0;
          data_write_2DM   <= '0;
          data_address_2DM <= '0;
          if (own_b) B_Done <= 1'b1;
          else       A_Done <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          A_Done  <= 1'b0;
          A_Err   <= 1'b0;
          B_Done  <= 1'b0;
          A_RData <= '0;
          B_RData <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_scheduler.sv
// Bench for dm_port_scheduler: directed vector table, arbitration/reset sequences, randomized A traffic vs a word-memory model.
module tb_dm_port_scheduler;

  logic        CLK;
  logic        RESET;
  logic        A_Req, A_Write, A_Signed;
  logic [1:0]  A_Size;
  logic [31:0] A_Addr, A_WData, A_RData;
  logic        A_Done, A_Err, A_Stall;
  logic        B_Req, B_Write;
  logic [31:0] B_Addr, B_WData, B_RData;
  logic        B_Done;
  logic [31:0] data_address_2DM, data_write_2DM, data_read_fDM;
  logic [1:0]  data_write_size_2DM;
  logic        MemRead_2DM, MemWrite_2DM;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  int checks = 0;
  int errors = 0;
  int nrd = 0;
  int nwr = 0;

  dm_port_scheduler dut (
    .CLK(CLK), .RESET(RESET),
    .A_Req(A_Req), .A_Write(A_Write), .A_Size(A_Size), .A_Signed(A_Signed),
    .A_Addr(A_Addr), .A_WData(A_WData), .A_RData(A_RData), .A_Done(A_Done),
    .A_Err(A_Err), .A_Stall(A_Stall),
    .B_Req(B_Req), .B_Write(B_Write), .B_Addr(B_Addr), .B_WData(B_WData),
    .B_RData(B_RData), .B_Done(B_Done),
    .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
    .data_write_size_2DM(data_write_size_2DM), .MemRead_2DM(MemRead_2DM),
    .MemWrite_2DM(MemWrite_2DM), .data_read_fDM(data_read_fDM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign data_read_fDM = MemRead_2DM ? mem[data_address_2DM[9:2]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: account for this cycle's DM strobes, apply the write at the edge, sample #1 after it.
  task automatic tick();
    chk("strobe_excl", 32'(MemRead_2DM & MemWrite_2DM), 32'h0);
    chk("wsize", 32'(data_write_size_2DM), 32'h0);
    if (!MemRead_2DM && !MemWrite_2DM)
      chk("bus_idle", data_address_2DM | data_write_2DM, 32'h0);
    if (MemRead_2DM) nrd++;
    if (MemWrite_2DM) begin
      nwr++;
      mem[data_address_2DM[9:2]] = data_write_2DM;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_a(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int nr, output int nw);
    A_Req = 1'b1; A_Write = w; A_Size = sz; A_Signed = sg; A_Addr = ad; A_WData = wd;
    nrd = 0; nwr = 0; lat = 0; rd = '0; er = 1'b0;
    #1;
    chk("a_stall_req", 32'(A_Stall), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (A_Done) begin
        lat = k; rd = A_RData; er = A_Err;
        chk("a_stall_done", 32'(A_Stall), 32'h0);
        break;
      end
    end
    if (lat == 0) chk("a_timeout", 32'(A_Done), 32'h1);
    nr = nrd; nw = nwr;
    A_Req = 1'b0;
    tick();
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] mw;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nr;
    int          nw;
    logic [31:0] mem_after;
  } vec_t;

  vec_t vq[$];

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, nr, nw;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    A_Req = 1'b1; A_Write = 1'b0; A_Size = 2'd0; A_Signed = 1'b0;
    A_Addr = 32'h100; A_WData = 32'h0;
    B_Req = 1'b1; B_Write = 1'b0; B_Addr = 32'h200; B_WData = 32'h0;
    RESET = 1'b0;

    // Reset state with both requests pending.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_a_done", 32'(A_Done), 32'h0);
    chk("rst_a_err", 32'(A_Err), 32'h0);
    chk("rst_a_stall", 32'(A_Stall), 32'h0);
    chk("rst_b_done", 32'(B_Done), 32'h0);
    chk("rst_rdata", A_RData | B_RData, 32'h0);
    chk("rst_strobes", 32'(MemRead_2DM | MemWrite_2DM), 32'h0);
    chk("rst_bus", data_address_2DM | data_write_2DM, 32'h0);
    A_Req = 1'b0; B_Req = 1'b0; RESET = 1'b1;
    tick();

    // w sz sg addr wdata memword | rdata err lat nr nw mem_after
    vq.push_back('{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        32'h11223344, 32'h11223344, 1'b0, 2, 1, 0, 32'h11223344});
    vq.push_back('{1'b1, 2'd1, 1'b0, 32'h101, 32'h000000AB, 32'h11223344, 32'h0,        1'b0, 3, 1, 1, 32'h11AB3344});
    vq.push_back('{1'b0, 2'd2, 1'b1, 32'h102, 32'h0,        32'h0000F00D, 32'hFFFFF00D, 1'b0, 2, 1, 0, 32'h0000F00D});
    vq.push_back('{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        32'h0000F00D, 32'h0000F00D, 1'b0, 2, 1, 0, 32'h0000F00D});
    vq.push_back('{1'b1, 2'd2, 1'b0, 32'h103, 32'h00001234, 32'h55667788, 32'h0,        1'b1, 1, 0, 0, 32'h55667788});
    vq.push_back('{1'b1, 2'd0, 1'b0, 32'h104, 32'hCAFEBABE, 32'h00000000, 32'h0,        1'b0, 2, 0, 1, 32'hCAFEBABE});
    vq.push_back('{1'b0, 2'd1, 1'b1, 32'h108, 32'h0,        32'h80FF0102, 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h80FF0102});
    vq.push_back('{1'b0, 2'd1, 1'b0, 32'h10B, 32'h0,        32'h80FF0182, 32'h00000082, 1'b0, 2, 1, 0, 32'h80FF0182});
    vq.push_back('{1'b0, 2'd0, 1'b0, 32'h10D, 32'h0,        32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'h12345678});
    vq.push_back('{1'b0, 2'd3, 1'b0, 32'h110, 32'h0,        32'hA5A50F0F, 32'hA5A50F0F, 1'b0, 2, 1, 0, 32'hA5A50F0F});
    vq.push_back('{1'b1, 2'd2, 1'b0, 32'h114, 32'h1234BEEF, 32'h11223344, 32'h0,        1'b0, 3, 1, 1, 32'hBEEF3344});
    vq.push_back('{1'b1, 2'd1, 1'b0, 32'h117, 32'h000000EE, 32'h11223344, 32'h0,        1'b0, 3, 1, 1, 32'h112233EE});
    vq.push_back('{1'b0, 2'd2, 1'b1, 32'h118, 32'h0,        32'h7FFF8000, 32'h00007FFF, 1'b0, 2, 1, 0, 32'h7FFF8000});
    vq.push_back('{1'b1, 2'd3, 1'b0, 32'h11A, 32'h0,        32'h0F0F0F0F, 32'h0,        1'b1, 1, 0, 0, 32'h0F0F0F0F});

    foreach (vq[i]) begin
      mem[vq[i].ad[9:2]] = vq[i].mw;
      do_a(vq[i].w, vq[i].sz, vq[i].sg, vq[i].ad, vq[i].wd, rd, er, lat, nr, nw);
      chk($sformatf("vec%0d_rdata", i), rd, vq[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vq[i].err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vq[i].lat));
      chk($sformatf("vec%0d_nrd", i), 32'(nr), 32'(vq[i].nr));
      chk($sformatf("vec%0d_nwr", i), 32'(nw), 32'(vq[i].nw));
      chk($sformatf("vec%0d_mem", i), mem[vq[i].ad[9:2]], vq[i].mem_after);
    end

    // Both requesters held: expect A,A,A,A,B repeating.
    begin
      int got;
      mem[8'h4C] = 32'h600DCAFE;
      mem[8'h80] = 32'h0BADF00D;
      A_Req = 1'b1; A_Write = 1'b0; A_Size = 2'd0; A_Signed = 1'b0; A_Addr = 32'h130;
      B_Req = 1'b1; B_Write = 1'b0; B_Addr = 32'h203;
      got = 0;
      for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
        tick();
        if (A_Done || B_Done) begin
          chk("starve_order", 32'(B_Done), 32'((got % 5) == 4));
          chk("starve_one_done", 32'(A_Done & B_Done), 32'h0);
          if (A_Done) chk("starve_a_rdata", A_RData, 32'h600DCAFE);
          if (B_Done) chk("starve_b_rdata", B_RData, 32'h0BADF00D);
          got++;
        end
      end
      if (got < 10) chk("starve_timeout", 32'(got), 32'd10);
      A_Req = 1'b0; B_Req = 1'b0;
      tick(); tick();
    end

    // Reset during the RD cycle of an SB aborts it without a write.
    begin
      logic saw_done;
      mem[8'h48] = 32'h11223344;
      A_Req = 1'b1; A_Write = 1'b1; A_Size = 2'd1; A_Signed = 1'b0;
      A_Addr = 32'h121; A_WData = 32'h000000AB;
      tick();
      chk("abort_rd_strobe", 32'(MemRead_2DM), 32'h1);
      RESET = 1'b0;
      #1;
      chk("abort_strobes", 32'(MemRead_2DM | MemWrite_2DM), 32'h0);
      chk("abort_bus", data_address_2DM | data_write_2DM, 32'h0);
      chk("abort_stall", 32'(A_Stall), 32'h0);
      chk("abort_done", 32'(A_Done | A_Err | B_Done), 32'h0);
      A_Req = 1'b0;
      nwr = 0; saw_done = 1'b0;
      tick(); tick();
      RESET = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (A_Done) saw_done = 1'b1;
      end
      chk("abort_no_write", 32'(nwr), 32'h0);
      chk("abort_no_done", 32'(saw_done), 32'h0);
      chk("abort_mem", mem[8'h48], 32'h11223344);
      do_a(1'b0, 2'd0, 1'b0, 32'h120, 32'h0, rd, er, lat, nr, nw);
      chk("post_rst_rdata", rd, 32'h11223344);
      chk("post_rst_lat", 32'(lat), 32'd2);
      chk("post_rst_nrd", 32'(nr), 32'd1);
    end

    // Randomized A traffic against a word-array model.
    for (int i = 192; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int t = 0; t < 150; t++) begin
      logic        w, sg, mis;
      logic [1:0]  sz;
      logic [31:0] ad, wd, word, mask, lane, e_rd, e_mem;
      int          nb, off, sh, e_lat, e_nr, e_nw;
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = 32'h300 + 32'($urandom_range(0, 255));
      wd = $urandom;
      nb  = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
      off = int'(ad[1:0]);
      mis = (off % nb) != 0;
      word = ref_mem[ad[9:2]];
      e_rd = '0;
      e_mem = word;
      if (!mis) begin
        sh   = (4 - off - nb) * 8;
        mask = (nb == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nb)) - 32'd1);
        if (w) e_mem = (word & ~(mask << sh)) | ((wd & mask) << sh);
        else begin
          lane = (word >> sh) & mask;
          if (sg && nb < 4 && lane[8 * nb - 1]) lane = lane | ~mask;
          e_rd = lane;
        end
      end
      e_lat = mis ? 1 : (w && nb < 4) ? 3 : 2;
      e_nr  = (mis || (w && nb == 4)) ? 0 : 1;
      e_nw  = (!mis && w) ? 1 : 0;
      ref_mem[ad[9:2]] = e_mem;
      do_a(w, sz, sg, ad, wd, rd, er, lat, nr, nw);
      chk("rand_rdata", rd, e_rd);
      chk("rand_err", 32'(er), 32'(mis));
      chk("rand_lat", 32'(lat), 32'(e_lat));
      chk("rand_nrd", 32'(nr), 32'(e_nr));
      chk("rand_nwr", 32'(nw), 32'(e_nw));
      chk("rand_mem", mem[ad[9:2]], ref_mem[ad[9:2]]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_port_scheduler.md
DM_PORT_SCHEDULER -- requirements
Module: dm_port_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK, RESET.
REQ-002 CLK  in  1  rising-edge clock.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 A_Req  in  1  MEM-stage request; held with all A_* fields until A_Done.
REQ-005 A_Write  in  1  1=store, 0=load.
REQ-006 A_Size  in  2  0=word, 1=byte, 2=half; 3 is treated as word.
REQ-007 A_Signed  in  1  sign-extend sub-word loads.
REQ-008 A_Addr  in  32  byte address.
REQ-009 A_WData  in  32  store data, right-justified.
REQ-010 A_RData  out  32  formatted load data, valid while A_Done=1.
REQ-011 A_Done  out  1  one-cycle completion pulse.
REQ-012 A_Err  out  1  misaligned flag, valid only with A_Done.
REQ-013 A_Stall  out  1  A_Req & ~A_Done.
REQ-014 B_Req, B_Write  in  1 each  second requester (loader/syscall), word-only, held until B_Done.
REQ-015 B_Addr, B_WData  in  32 each  B address (bits [1:0] ignored) and data.
REQ-016 B_RData  out  32; B_Done  out  1  same semantics as A_RData and A_Done.
REQ-017 data_address_2DM  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-018 data_write_2DM  out  32; data_write_size_2DM  out  2  (always 0, full word).
REQ-019 MemRead_2DM, MemWrite_2DM  out  1 each; data_read_fDM  in  32  (combinational, valid in the same cycle as MemRead_2DM).

Function
REQ-020 The FSM SHALL have the states IDLE, RD, WR and DONE; the owner (A or B) and the request fields SHALL be latched on grant.
REQ-021 IDLE: grant A if A_Req, else B if B_Req; B SHALL win when B_Req and starve_cnt==4.
REQ-022 starve_cnt (3 bits) SHALL increment each IDLE cycle in which A is granted while B_Req=1, saturate at 4, and clear on any B grant.
REQ-023 Grant transitions: load->RD; word store->WR; sub-word store->RD (read-modify-write); misaligned (half with addr[0]=1, word with addr[1:0]!=0)->DONE with A_Err=1 and no DM strobe.
REQ-024 RD SHALL drive MemRead_2DM=1 and capture data_read_fDM at the clock edge. Loads then go to DONE; sub-word stores go to WR with the merged word.
REQ-025 Byte lanes are big-endian: offset 0 is [31:24], offset 3 is [7:0]; halfword offset 0 is [31:16], offset 2 is [15:0].
REQ-026 Loads SHALL extract the lane and zero-extend, or sign-extend when A_Signed=1; word loads SHALL return the word unchanged.
REQ-027 Merge SHALL replace only the addressed lane with A_WData[7:0] or A_WData[15:0] and preserve all other bits.
REQ-028 WR SHALL drive MemWrite_2DM=1 with the word for exactly one cycle, then go to DONE.
REQ-029 DONE SHALL pulse the owner's Done for one cycle, with RData registered (0 for stores), then return to IDLE; no new grant is made in DONE.
REQ-030 Latency from request in IDLE at cycle t: load and word store Done at t+2; sub-word store Done at t+3; misaligned Done at t+1.
REQ-031 Outside RD/WR the block SHALL drive MemRead_2DM, MemWrite_2DM, data_address_2DM and data_write_2DM to 0.
REQ-032 MemRead_2DM and MemWrite_2DM SHALL never both be 1.
REQ-033 A request dropped before Done is a protocol violation; the block SHALL still complete the latched operation.

Reset
REQ-034 RESET=0 SHALL immediately force IDLE, starve_cnt=0, and all outputs to 0, including the Done, Err and strobe outputs.
REQ-035 Reset asserted in RD or WR SHALL abort the operation: no further strobe is issued and no Done is given for it.

Verification
REQ-036 A word load at 0x100 with DM word 0x11223344: A_Done at t+2, A_RData=0x11223344, one MemRead cycle.
REQ-037 SB of 0xAB to 0x101 over DM word 0x11223344: RD then WR; data_write_2DM=0x11AB3344; A_Done at t+3.
REQ-038 LH with A_Signed=1 at 0x102 over DM word 0x0000F00D: A_RData=0xFFFFF00D. The same access with A_Signed=0: A_RData=0x0000F00D.
REQ-039 A_Req and B_Req held high continuously: A is granted 4 times, then B once; the pattern repeats and B_Done is never starved.
REQ-040 SH to 0x103: A_Done and A_Err at t+1, with no MemRead_2DM or MemWrite_2DM pulse.
REQ-041 RESET asserted during the RD cycle of an SB: no MemWrite_2DM occurs, all outputs read 0, and a new request after release runs normally.
